fetch_prefetch_unit: RTL
========================

Name: fetch_prefetch_unit

Overview:
Parametrised successor to the single-PC fetch stage. Decouples instruction fetch from decode with a DEPTH-entry prefetch queue and a 1-cycle synchronous imem interface. Handles jump redirect with queue flush and squash of the in-flight read, and an external hold for interrupt and mult/div serialisation. Sits between imem and the F/D latch; decode consumes entries through a valid/ready handshake.

Parameters:
ADDR_W, 32, PC / imem address width
INSN_W, 32, instruction width
DEPTH, 4, prefetch queue entries; power of two, >= 2
RESET_PC, 0, PC value loaded on reset

Ports:
clock  in  1  master clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  read issued this cycle
imem_addr  out  ADDR_W  address of read; equals current PC
imem_data  in  INSN_W  data for the address issued in the previous cycle
redirect  in  1  jump taken; flush and restart at redirect_pc
redirect_pc  in  ADDR_W  jump target
hold  in  1  interrupt pending or mult/div in F/D or D/X; suppress new issues
dec_valid  out  1  queue head valid for decode
dec_instr  out  INSN_W  queue head instruction
dec_pc_plus1  out  ADDR_W  address of head instruction + 1
dec_ready  in  1  decode accepts head (not stalled)
occupancy  out  $clog2(DEPTH)+1  entries currently queued

Behaviour:
- Reset (clock edge with reset=1): pc<=RESET_PC, queue empty, inflight_v<=0, occupancy=0. imem_req=0 and dec_valid=0 while reset is high.
- State: pc, inflight_v, inflight_pc, queue (rd/wr pointers mod DEPTH, count).
- pop = dec_valid & dec_ready. dec_valid = (count!=0) & ~redirect.
- free = DEPTH - count - inflight_v + pop. Issue when ~reset & ~redirect & ~hold & free>0.
- On issue: imem_req=1, imem_addr=pc. Next edge: pc<=pc+1 (wraps mod 2^ADDR_W), inflight_v<=1, inflight_pc<=pc.
- No issue: inflight_v<=0; pc unchanged.
- Response: when inflight_v=1, imem_data is pushed into the queue with tag inflight_pc+1 (wrapping), unless squashed. The queue never overflows, because free accounts for the in-flight read.
- Full throughput: steady state with dec_ready=1 and no hold gives 1 issue, 1 push, 1 pop per cycle. Minimum latency from issue to dec_valid is 2 cycles (issue t, push at end of t+1, head visible t+2).
- Simultaneous push and pop: count unchanged; pointers both advance.
- Empty queue: dec_valid=0. dec_instr and dec_pc_plus1 are don't-care but hold their last value.
- Redirect (priority over everything): dec_valid forced 0, no pop, no issue that cycle. Next edge: queue cleared, inflight_v<=0 (any response arriving next cycle is dropped), pc<=redirect_pc. Issue of redirect_pc happens the following cycle if not held.
- Redirect and reset together: reset wins.
- Back-to-back redirects: the last one wins; each flushes.
- Hold: blocks only new issues. The in-flight response still lands, and pops continue. Deasserting hold resumes issue from the retained pc the same cycle.
- occupancy = count; it excludes the in-flight read.

Decomposition:
- Shared package fetch_pkg holds ADDR_W/INSN_W defaults, RESET_PC default, and the NOP encoding (32'b0) used by decode for bubbles.
- One sub-module: fetch_queue. It is a circular FIFO with parametrised DEPTH/width, push, pop and synchronous flush, and exposes count/empty/full. The PC and issue logic stay in fetch_prefetch_unit.

Test Plan:
- Reset with RESET_PC=0x10, then release; dec_ready=1 -> imem_addr 0x10,0x11,0x12 on consecutive cycles; dec_valid first high 2 cycles after the first issue with dec_pc_plus1=0x11; one pop per cycle thereafter.
- dec_ready=0 from the start, DEPTH=4 -> exactly 4 issues, occupancy reaches 4, imem_req stays 0 with pc=RESET_PC+4. Raise dec_ready -> first pop returns instr@RESET_PC, and the issue resumes the same cycle.
- Queue holds 3 entries with one read in flight; assert redirect with redirect_pc=0x40 for 1 cycle -> dec_valid=0 that cycle; next cycle occupancy=0 and imem_addr=0x40; the stale response never appears at the decode head.
- hold=1 for 5 cycles mid-stream -> no imem_req during hold; the in-flight entry is still queued and pops continue; the first issue after release is at the next sequential pc.
- pc=2^ADDR_W-1 (via redirect to 0xFFFFFFFF) -> next issued address is 0x0; dec_pc_plus1 for that entry is 0x0.
- Reset asserted mid-stream with queue full and a read in flight -> next cycle occupancy=0, dec_valid=0, pc=RESET_PC; no stale entry appears after reset deasserts.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions.
// Default address/instruction widths, the reset PC default, and the NOP
// encoding that decode inserts as a bubble. Also used here as the value the
// queue head shows before any instruction has been fetched.
package fetch_pkg;

   localparam int unsigned ADDR_W_DEF   = 32;
   localparam int unsigned INSN_W_DEF   = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP_INSN     = 32'b0;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO used as the instruction prefetch queue.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   flush             : synchronous clear of all entries (pointers and count)
//   push, push_data   : write one entry at the tail
//   pop               : remove the head entry
//   head_data         : head entry; holds the last shown head while empty
//   count             : entries stored (0..DEPTH)
//   empty, full       : count==0 / count==DEPTH
// DEPTH must be a power of two (pointers wrap naturally), and >= 2.
module fetch_queue #(
   parameter int unsigned      DEPTH      = 4,
   parameter int unsigned      WIDTH      = 64,
   parameter logic [WIDTH-1:0] IDLE_VALUE = '0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [WIDTH-1:0] last_head;

   assign empty = (count == '0);
   assign full  = (count == (PW+1)'(DEPTH));

   // While empty, the storage slot at rd_ptr is stale; present the last
   // real head instead so downstream sees a stable value.
   assign head_data = empty ? last_head : mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         last_head <= IDLE_VALUE;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (!empty) last_head <= mem[rd_ptr];
         if (push)   wr_ptr    <= wr_ptr + PW'(1);
         if (pop)    rd_ptr    <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push && !flush && !reset) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch with a DEPTH-entry prefetch queue.
// Issues sequential reads to a 1-cycle synchronous imem, queues responses
// tagged with pc+1, and hands them to decode over a valid/ready handshake.
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   imem_req, imem_addr     : read issued this cycle, at the current pc
//   imem_data               : data for the previous cycle's read
//   redirect, redirect_pc   : jump taken; flush queue, drop in-flight read
//   hold                    : suppress new issues (in-flight read still lands)
//   dec_valid, dec_ready    : decode handshake on the queue head
//   dec_instr, dec_pc_plus1 : head instruction and its address + 1
//   occupancy               : queued entries, excluding the in-flight read
module fetch_prefetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = ADDR_W_DEF,
   parameter int unsigned       INSN_W   = INSN_W_DEF,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic                   clock,
   input  logic                   reset,
   output logic                   imem_req,
   output logic [ADDR_W-1:0]      imem_addr,
   input  logic [INSN_W-1:0]      imem_data,
   input  logic                   redirect,
   input  logic [ADDR_W-1:0]      redirect_pc,
   input  logic                   hold,
   output logic                   dec_valid,
   output logic [INSN_W-1:0]      dec_instr,
   output logic [ADDR_W-1:0]      dec_pc_plus1,
   input  logic                   dec_ready,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned EW = ADDR_W + INSN_W;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight_v;
   logic              issue;
   logic              pop;
   logic              push;
   logic              q_empty;
   logic              q_full;
   logic [CW-1:0]     count;
   logic [CW:0]       used;
   logic [CW:0]       cap;
   logic [EW-1:0]     head;

   assign dec_valid = ~reset & ~redirect & ~q_empty;
   assign pop       = dec_valid & dec_ready;

   // Issue only if the queue has room for this read after the in-flight one
   // lands, counting a slot freed by this cycle's pop:
   // count + inflight_v < DEPTH + pop.
   always_comb begin
      used  = {1'b0, count} + (CW+1)'(inflight_v);
      cap   = (CW+1)'(DEPTH) + (CW+1)'(pop);
      issue = ~reset & ~redirect & ~hold & (used < cap);
   end

   assign imem_req  = issue;
   assign imem_addr = pc;

   // A response coinciding with redirect is discarded by the flush; the
   // full guard never fires given the issue rule above.
   assign push = inflight_v & ~redirect & ~(q_full & ~pop);

   fetch_queue #(
      .DEPTH      (DEPTH),
      .WIDTH      (EW),
      .IDLE_VALUE ({{ADDR_W{1'b0}}, INSN_W'(NOP_INSN)})
   ) u_queue (
      .clock     (clock),
      .reset     (reset),
      .flush     (redirect),
      .push      (push),
      .push_data ({inflight_pc + ADDR_W'(1), imem_data}),
      .pop       (pop),
      .head_data (head),
      .count     (count),
      .empty     (q_empty),
      .full      (q_full)
   );

   assign dec_instr    = head[INSN_W-1:0];
   assign dec_pc_plus1 = head[EW-1 -: ADDR_W];
   assign occupancy    = count;

   always_ff @(posedge clock) begin
      if (reset) begin
         pc          <= RESET_PC;
         inflight_v  <= 1'b0;
         inflight_pc <= '0;
      end else if (redirect) begin
         pc         <= redirect_pc;
         inflight_v <= 1'b0;
      end else begin
         inflight_v <= issue;
         if (issue) begin
            pc          <= pc + ADDR_W'(1);
            inflight_pc <= pc;
         end
      end
   end

endmodule
